// File: rtl/debug_console_wb_if.sv
// Wishbone pipelined slave bus plus the outgoing character stream of the debug console.
// The master side is the bus initiator, which also acts as the character sink.
interface debug_console_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_stall_o;
  logic [31:0] wb_dat_o;
  logic        char_valid_o;
  logic [7:0]  char_data_o;
  logic        char_ready_i;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, char_ready_i,
    input  wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o, char_valid_o, char_data_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, char_ready_i,
    output wb_ack_o, wb_err_o, wb_stall_o, wb_dat_o, char_valid_o, char_data_o
  );
endinterface

// File: rtl/debug_console_wb.sv
// Wishbone debug console: TX character FIFO, sticky overflow, test result latch, cycle counter.
// Optional DEBUG_CONSOLE_SIM_PRINT_EN echoes popped characters and result writes to the simulator console.
module debug_console_wb #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  debug_console_wb_if.slave bus,
  output logic              test_done_o,
  output logic              test_pass_o
);

  localparam int AW = CNT_W - 1;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_RESULT = 2'd2,
    REG_CYCLES = 2'd3
  } reg_e;

  reg_e              w_addr;
  logic              w_access;
  logic              w_bad;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic              w_res_wr;
  logic [31:0]       w_rdata;
  logic              w_unused;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic [15:0]       r_code;
  logic              r_done;
  logic              r_pass;
  logic [31:0]       r_cycles;
  logic              r_ack_p1;
  logic              r_err_p1;
  logic [31:0]       r_rdata_p1;

  assign w_addr   = reg_e'(bus.wb_adr_i[3:2]);
  assign w_access = bus.wb_cyc_i & bus.wb_stb_i;
  // Reads of the write-only TX port and writes to the read-only counter are bus errors.
  assign w_bad    = ((w_addr == REG_TXDATA) & ~bus.wb_we_i) |
                    ((w_addr == REG_CYCLES) &  bus.wb_we_i);

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = ~w_empty & bus.char_ready_i;
  assign w_push_req = w_access & bus.wb_we_i & (w_addr == REG_TXDATA) & bus.wb_sel_i[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_access & bus.wb_we_i & (w_addr == REG_STATUS) & bus.wb_dat_i[18];
  assign w_res_wr   = w_access & bus.wb_we_i & (w_addr == REG_RESULT);

  assign w_unused = ^{bus.wb_adr_i[31:4], bus.wb_adr_i[1:0], bus.wb_sel_i[3:1],
                      bus.wb_dat_i[31:19], bus.wb_dat_i[17:16]};

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      REG_STATUS: begin
        w_rdata[CNT_W-1:0] = r_count;
        w_rdata[16]        = w_empty;
        w_rdata[17]        = w_full;
        w_rdata[18]        = r_ovf;
        w_rdata[19]        = r_done;
        w_rdata[20]        = r_pass;
      end
      REG_RESULT: w_rdata = {15'd0, r_done, r_code};
      REG_CYCLES: w_rdata = r_cycles;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_code   <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
      if (w_res_wr) begin
        r_code <= bus.wb_dat_i[15:0];
        r_done <= 1'b1;
        r_pass <= (bus.wb_dat_i[15:0] == 16'h0001);
      end
    end
  end

  // Response stage: one registered ack/err per access, read data only with ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_ack_p1   <= 1'b0;
      r_err_p1   <= 1'b0;
      r_rdata_p1 <= '0;
    end else begin
      r_ack_p1   <= w_access & ~w_bad;
      r_err_p1   <= w_access &  w_bad;
      r_rdata_p1 <= (w_access & ~w_bad & ~bus.wb_we_i) ? w_rdata : '0;
    end
  end

  assign bus.wb_ack_o     = r_ack_p1;
  assign bus.wb_err_o     = r_err_p1;
  assign bus.wb_stall_o   = 1'b0;
  assign bus.wb_dat_o     = r_rdata_p1;
  assign bus.char_valid_o = ~w_empty;
  assign bus.char_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign test_done_o      = r_done;
  assign test_pass_o      = r_pass;

`ifdef DEBUG_CONSOLE_SIM_PRINT_EN
  always @(posedge wb_clk_i) begin
    if (wb_rst_ni && w_pop) $write("%c", bus.char_data_o);
    if (wb_rst_ni && w_res_wr) begin
      if (bus.wb_dat_i[15:0] == 16'h0001) $display("Success!");
      else                                $display("Failure! code=%h", bus.wb_dat_i[15:0]);
    end
  end
`endif

endmodule

// File: tb/tb_debug_console_wb.sv
// Directed-plus-random bench for debug_console_wb against a queue-based model of the console.
module tb_debug_console_wb;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic test_done, test_pass;

  debug_console_wb_if bus_if ();

  debug_console_wb #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .bus         (bus_if),
    .test_done_o (test_done),
    .test_pass_o (test_pass)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Clock edges seen since reset release: the expected CYCLES value.
  int unsigned tb_edges;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_edges <= 0;
    else        tb_edges <= tb_edges + 1;
  end

  byte unsigned m_q[$];
  bit           m_ovf;
  bit [15:0]    m_code;
  bit           m_done;

  function automatic logic [31:0] m_status();
    logic [31:0] r;
    r     = 32'(m_q.size());
    r[16] = (m_q.size() == 0);
    r[17] = (m_q.size() == FIFO_DEPTH);
    r[18] = m_ovf;
    r[19] = m_done;
    r[20] = m_done && (m_code == 16'h0001);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit we, input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel);
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
    bus_if.wb_we_i  = we;
    bus_if.wb_adr_i = {28'($urandom), r, 2'($urandom)};
    bus_if.wb_dat_i = d;
    bus_if.wb_sel_i = sel;
  endtask

  task automatic idle();
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  task automatic bus_op(input bit we, input logic [1:0] r, input logic [31:0] d, input logic [3:0] sel,
                        output logic [31:0] rd, output logic ack, output logic err);
    drive(we, r, d, sel);
    tick();
    idle();
    rd  = bus_if.wb_dat_o;
    ack = bus_if.wb_ack_o;
    err = bus_if.wb_err_o;
  endtask

  task automatic read_reg(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] rd;
    logic ack, err;
    bus_op(1'b0, r, 32'($urandom), 4'hF, rd, ack, err);
    check({tag, "_ack"}, 32'(ack), 32'd1);
    check({tag, "_dat"}, rd, exp);
  endtask

  task automatic wr_char(input byte unsigned c, input bit sel0);
    logic [31:0] rd;
    logic ack, err;
    bus_op(1'b1, 2'd0, {24'($urandom), c}, {3'($urandom), sel0}, rd, ack, err);
    check("tx_ack", {30'd0, ack, err}, 32'd2);
    if (sel0) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(c);
      else                         m_ovf = 1'b1;
    end
  endtask

  task automatic drain();
    bus_if.char_ready_i = 1'b1;
    for (int k = 0; k < FIFO_DEPTH + 2 && m_q.size() > 0; k++) begin
      check("drain_valid", 32'(bus_if.char_valid_o), 32'd1);
      check("drain_data", 32'(bus_if.char_data_o), 32'(m_q[0]));
      tick();
      void'(m_q.pop_front());
    end
    bus_if.char_ready_i = 1'b0;
    check("drain_empty", 32'(bus_if.char_valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, exp;
    logic ack, err;
    byte unsigned c;
    int n;

    idle();
    bus_if.wb_adr_i     = '0;
    bus_if.wb_dat_i     = '0;
    bus_if.wb_sel_i     = '0;
    bus_if.char_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_ack",   32'(bus_if.wb_ack_o), 32'd0);
    check("rst_err",   32'(bus_if.wb_err_o), 32'd0);
    check("rst_dat",   bus_if.wb_dat_o, 32'd0);
    check("rst_valid", 32'(bus_if.char_valid_o), 32'd0);
    check("rst_char",  32'(bus_if.char_data_o), 32'd0);
    check("rst_done",  {30'd0, test_done, test_pass}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) tick();
    check("idle_outs", {28'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.wb_stall_o, bus_if.char_valid_o}, 32'd0);
    check("idle_dat", bus_if.wb_dat_o, 32'd0);
    exp = tb_edges;
    bus_op(1'b0, 2'd3, 32'd0, 4'hF, rd, ack, err);
    check("cycles_ack", {30'd0, ack, err}, 32'd2);
    check("cycles_val", rd, exp);
    check("cycles_rng", 32'(rd >= 10 && rd <= 12), 32'd1);
    tick();
    check("noack_dat", bus_if.wb_dat_o, 32'd0);
    read_reg("status0", 2'd1, m_status());

    // Two characters streamed straight through with the sink ready.
    bus_if.char_ready_i = 1'b1;
    drive(1'b1, 2'd0, 32'h0000_0048, 4'h1);
    tick();
    check("hi_ack0", 32'(bus_if.wb_ack_o), 32'd1);
    check("hi_c0", {23'd0, bus_if.char_valid_o, bus_if.char_data_o}, 32'h148);
    drive(1'b1, 2'd0, 32'hABCD_0069, 4'hF);
    tick();
    idle();
    check("hi_c1", {23'd0, bus_if.char_valid_o, bus_if.char_data_o}, 32'h169);
    tick();
    check("hi_end", {23'd0, bus_if.char_valid_o, bus_if.char_data_o}, 32'h000);
    bus_if.char_ready_i = 1'b0;

    // Overfill with random characters; sel[0]=0 write must not push.
    wr_char(8'($urandom), 1'b0);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) wr_char(8'($urandom), 1'b1);
    read_reg("status_full", 2'd1, m_status());
    check("ovf_model", 32'(m_ovf), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("hold_data", {23'd0, bus_if.char_valid_o, bus_if.char_data_o}, {23'd0, 1'b1, m_q[0]});
    end
    bus_op(1'b1, 2'd1, 32'($urandom) | 32'h0004_0000, 4'hF, rd, ack, err);
    check("w1c_ack", {30'd0, ack, err}, 32'd2);
    m_ovf = 1'b0;
    read_reg("status_w1c", 2'd1, m_status());
    drain();

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < FIFO_DEPTH; i++) wr_char(8'($urandom), 1'b1);
    c = 8'($urandom);
    bus_if.char_ready_i = 1'b1;
    drive(1'b1, 2'd0, {24'd0, c}, 4'h1);
    tick();
    idle();
    bus_if.char_ready_i = 1'b0;
    check("pp_ack", 32'(bus_if.wb_ack_o), 32'd1);
    void'(m_q.pop_front());
    m_q.push_back(c);
    read_reg("status_pp", 2'd1, m_status());
    drain();

    n = $urandom_range(1, FIFO_DEPTH - 1);
    for (int i = 0; i < n; i++) wr_char(8'($urandom), 1'($urandom));
    read_reg("status_rand", 2'd1, m_status());
    drain();

    // Test result latch.
    bus_op(1'b1, 2'd2, 32'h0000_0001, 4'hF, rd, ack, err);
    m_code = 16'h0001; m_done = 1'b1;
    check("res1_flags", {30'd0, test_done, test_pass}, 32'd3);
    read_reg("res1_read", 2'd2, {15'd0, m_done, m_code});
    m_code = 16'($urandom_range(2, 65535));
    bus_op(1'b1, 2'd2, {16'($urandom), m_code}, 4'hF, rd, ack, err);
    check("resx_flags", {30'd0, test_done, test_pass}, 32'd2);
    bus_op(1'b1, 2'd2, 32'($urandom) & 32'hFFFF_0000, 4'hF, rd, ack, err);
    m_code = 16'h0000;
    check("res0_flags", {30'd0, test_done, test_pass}, 32'd2);
    read_reg("res0_read", 2'd2, 32'h0001_0000);
    read_reg("status_res", 2'd1, m_status());

    // Error accesses leave state untouched.
    wr_char(8'($urandom), 1'b1);
    wr_char(8'($urandom), 1'b1);
    bus_op(1'b0, 2'd0, 32'd0, 4'hF, rd, ack, err);
    check("err_rdtx", {rd[29:0], ack, err}, 32'd1);
    tick();
    check("err_pulse", {30'd0, bus_if.wb_ack_o, bus_if.wb_err_o}, 32'd0);
    bus_op(1'b1, 2'd3, 32'($urandom), 4'hF, rd, ack, err);
    check("err_wrcyc", {30'd0, ack, err}, 32'd1);
    read_reg("status_err", 2'd1, m_status());
    read_reg("result_err", 2'd2, {15'd0, m_done, m_code});

    // Reset asserted in the middle of an access.
    drive(1'b0, 2'd1, 32'd0, 4'hF);
    #2 rst_n = 1'b0;
    #1 idle();
    m_q.delete(); m_ovf = 1'b0; m_code = '0; m_done = 1'b0;
    check("mid_rst", {27'd0, bus_if.wb_ack_o, bus_if.wb_err_o, bus_if.char_valid_o, test_done, test_pass}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", {30'd0, bus_if.wb_ack_o, bus_if.wb_err_o}, 32'd0);
    tick();
    check("post_rst_ack2", {30'd0, bus_if.wb_ack_o, bus_if.wb_err_o}, 32'd0);
    read_reg("status_rst", 2'd1, m_status());
    read_reg("result_rst", 2'd2, 32'd0);
    exp = tb_edges;
    read_reg("cycles_rst", 2'd3, exp);
    check("stall", 32'(bus_if.wb_stall_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
